// File: rtl/falconsoar_pkg.sv
// falconsoar_pkg: shared constants and types for the FALCON-SOAR task
// dispatch path.
//  - Cluster count and task widths
//  - Bit positions of the task header (barrier flag, cluster id)
//  - Dispatcher FSM state encoding
//  - cid_onehot(): cluster id -> per-cluster one-hot vector (END maps to 0)
package falconsoar_pkg;

    localparam int EXEC_CLUSTER_NUM = 7;
    localparam int TASK_BW          = 72;
    localparam int TASK_REDUCE_BW   = 68;

    // Header layout of task_complete_t
    localparam int TASK_BARRIER_BIT = 71;
    localparam int TASK_CID_MSB     = 70;
    localparam int TASK_CID_LSB     = 68;

    typedef logic [2:0]                cluster_id_t;
    typedef logic [TASK_REDUCE_BW-1:0] task_reduce_t;

    // Id 7 is not a cluster: it marks the end of the task stream
    localparam cluster_id_t CID_END = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } disp_state_t;

    // CID_END has no cluster, so it yields an all-zero vector
    function automatic logic [EXEC_CLUSTER_NUM-1:0] cid_onehot(input cluster_id_t cid);
        logic [EXEC_CLUSTER_NUM-1:0] oh;
        oh = '0;
        for (int k = 0; k < EXEC_CLUSTER_NUM; k++)
            oh[k] = (cid == cluster_id_t'(k));
        return oh;
    endfunction

endpackage

// File: rtl/falconsoar_busy_tracker.sv
// falconsoar_busy_tracker: per-cluster busy flags for the task dispatcher.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset
//  set_vec     one-hot: a task was accepted for this cluster this cycle
//  op_done     per-cluster completion pulses from the clusters
//  busy        registered busy flag per cluster
//  all_idle    no cluster busy (from the registered flags)
//  err         sticky: a completion pulse arrived on a cluster that was not busy
module falconsoar_busy_tracker
    import falconsoar_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [EXEC_CLUSTER_NUM-1:0] set_vec,
    input  logic [EXEC_CLUSTER_NUM-1:0] op_done,
    output logic [EXEC_CLUSTER_NUM-1:0] busy,
    output logic                        all_idle,
    output logic                        err
);

    // Completions only count on clusters that are busy; the rest are spurious
    logic [EXEC_CLUSTER_NUM-1:0] clr_vec;
    logic [EXEC_CLUSTER_NUM-1:0] spurious;

    assign clr_vec  = op_done & busy;
    assign spurious = op_done & ~busy;
    assign all_idle = (busy == '0);

    // The dispatcher only sets a flag that is currently clear, while a clear
    // needs the flag to be set, so set and clear never target the same
    // cluster in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
            if (|spurious)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/falconsoar_task_dispatcher.sv
// falconsoar_task_dispatcher: issues the 72-bit task stream to the execution
// clusters (Hash, HashToPoint, ctrlA, sampling, ctrlB, post, Huffman).
// The 4-bit header is stripped and the 68-bit payload forwarded unchanged.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  run_i        pulse: start executing the task stream (only honoured in S_IDLE)
//  task_vld_i   upstream task valid
//  task_i       [71]=barrier, [70:68]=cluster id (7=END), [67:0]=payload
//  task_rdy_o   combinational ready; accept = task_vld_i & task_rdy_o
//  start_o      per-cluster start pulse, one cycle after acceptance
//  task_o       per-cluster payload, held until that cluster's next start
//  op_done_i    per-cluster completion pulse
//  busy_o       dispatcher not in S_IDLE
//  done_o       one-cycle pulse once END is consumed and every cluster is idle
//  err_o        sticky: completion seen on a non-busy cluster
// Optional: FALCONSOAR_DISPATCH_PERF_EN adds perf_task_cnt_o (accepted
// non-END tasks) and perf_stall_cnt_o (S_RUN cycles with valid but no ready).
// Both clear on an accepted run_i and saturate.
module falconsoar_task_dispatcher
    import falconsoar_pkg::*;
(
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            run_i,
    input  logic                                            task_vld_i,
    input  logic [TASK_BW-1:0]                              task_i,
    output logic                                            task_rdy_o,
    output logic [EXEC_CLUSTER_NUM-1:0]                     start_o,
    output logic [EXEC_CLUSTER_NUM-1:0][TASK_REDUCE_BW-1:0] task_o,
    input  logic [EXEC_CLUSTER_NUM-1:0]                     op_done_i,
    output logic                                            busy_o,
    output logic                                            done_o,
    output logic                                            err_o
`ifdef FALCONSOAR_DISPATCH_PERF_EN
    ,
    output logic [31:0]                                     perf_task_cnt_o,
    output logic [31:0]                                     perf_stall_cnt_o
`endif
);

    disp_state_t                 state;
    logic [EXEC_CLUSTER_NUM-1:0] busy;
    logic                        all_idle;

    // Header decode
    logic         barrier;
    cluster_id_t  cid;
    task_reduce_t payload;
    logic         is_end;

    assign barrier = task_i[TASK_BARRIER_BIT];
    assign cid     = task_i[TASK_CID_MSB:TASK_CID_LSB];
    assign payload = task_i[TASK_REDUCE_BW-1:0];
    assign is_end  = (cid == CID_END);

    // Extended with a constant-0 slot so the END id can index it safely
    logic [EXEC_CLUSTER_NUM:0] busy_ext;
    assign busy_ext = {1'b0, busy};

    // Ready uses the registered flags only: a cluster finishing in cycle C
    // can take its next task in C+1 at the earliest.
    assign task_rdy_o = (state == S_RUN) &&
                        (is_end || !busy_ext[cid]) &&
                        (!barrier || all_idle);

    logic                        accept;
    logic [EXEC_CLUSTER_NUM-1:0] set_vec;

    assign accept  = task_vld_i && task_rdy_o;
    assign set_vec = accept ? cid_onehot(cid) : '0;

    falconsoar_busy_tracker u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_vec  (set_vec),
        .op_done  (op_done_i),
        .busy     (busy),
        .all_idle (all_idle),
        .err      (err_o)
    );

    assign busy_o = (state != S_IDLE);

    // FSM with registered done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE:  if (run_i) state <= S_RUN;
                S_RUN:   if (accept && is_end) state <= S_DRAIN;
                S_DRAIN: if (all_idle) begin
                    state  <= S_DONE;
                    done_o <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Start pulses and per-cluster payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_o <= '0;
            task_o  <= '0;
        end else begin
            start_o <= set_vec;
            for (int k = 0; k < EXEC_CLUSTER_NUM; k++)
                if (set_vec[k])
                    task_o[k] <= payload;
        end
    end

`ifdef FALCONSOAR_DISPATCH_PERF_EN
    logic run_go;
    logic stall;

    assign run_go = (state == S_IDLE) && run_i;
    assign stall  = (state == S_RUN) && task_vld_i && !task_rdy_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_task_cnt_o  <= '0;
            perf_stall_cnt_o <= '0;
        end else if (run_go) begin
            perf_task_cnt_o  <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (accept && !is_end && perf_task_cnt_o != 32'hFFFF_FFFF)
                perf_task_cnt_o <= perf_task_cnt_o + 32'd1;
            if (stall && perf_stall_cnt_o != 32'hFFFF_FFFF)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_falconsoar_task_dispatcher.sv
// Directed testbench for falconsoar_task_dispatcher. Inputs are driven 1ns
// after the rising edge; outputs are sampled there or 1ns later.
module tb_falconsoar_task_dispatcher;

    logic             clk;
    logic             rst_n;
    logic             run_i;
    logic             task_vld_i;
    logic [71:0]      task_i;
    logic             task_rdy_o;
    logic [6:0]       start_o;
    logic [6:0][67:0] task_o;
    logic [6:0]       op_done_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
`ifdef FALCONSOAR_DISPATCH_PERF_EN
    logic [31:0]      perf_task_cnt_o;
    logic [31:0]      perf_stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int st3_cnt = 0;

    falconsoar_task_dispatcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run_i),
        .task_vld_i (task_vld_i),
        .task_i     (task_i),
        .task_rdy_o (task_rdy_o),
        .start_o    (start_o),
        .task_o     (task_o),
        .op_done_i  (op_done_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
`ifdef FALCONSOAR_DISPATCH_PERF_EN
        ,
        .perf_task_cnt_o  (perf_task_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts start pulses on cluster 3, sampled mid-cycle
    always @(negedge clk) if (start_o[3]) st3_cnt <= st3_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run();
        run_i = 1'b1;
        step();
        run_i = 1'b0;
    endtask

    task automatic end_drain();
        task_vld_i = 1'b1;
        task_i     = {1'b0, 3'd7, 68'h0};
        step();
        task_vld_i = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run_i = 1'b0; task_vld_i = 1'b0;
        task_i = '0; op_done_i = '0;
        step();
        n_tests++; if (start_o !== 7'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", start_o); end
        n_tests++; if (task_o !== '0) begin n_fail++; $display("FAIL rst_task_o: got %h want 0", task_o); end
        n_tests++; if ({busy_o, done_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {busy_o, done_o, err_o}); end
        rst_n = 1'b1;
        step();
        task_vld_i = 1'b1; task_i = {1'b0, 3'd2, 68'h1};
        #1;
        n_tests++; if (task_rdy_o !== 1'b0) begin n_fail++; $display("FAIL idle_rdy: got %b want 0", task_rdy_o); end
        task_vld_i = 1'b0;
    endtask

    task automatic test_basic();
        do_run();
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy_o); end
        task_vld_i = 1'b1; task_i = {1'b0, 3'd2, 68'hA5};
        #1;
        n_tests++; if (task_rdy_o !== 1'b1) begin n_fail++; $display("FAIL t1_rdy: got %b want 1", task_rdy_o); end
        step();
        task_vld_i = 1'b0;
        n_tests++; if (start_o !== 7'b0000100) begin n_fail++; $display("FAIL t1_start: got %b want 0000100", start_o); end
        n_tests++; if (task_o[2] !== 68'hA5) begin n_fail++; $display("FAIL t1_task_o: got %h want a5", task_o[2]); end
        step();
        n_tests++; if (start_o !== 7'b0) begin n_fail++; $display("FAIL t1_start_once: got %b want 0", start_o); end
        n_tests++; if (task_o[2] !== 68'hA5) begin n_fail++; $display("FAIL t1_task_hold: got %h want a5", task_o[2]); end
        op_done_i[2] = 1'b1;
        step();
        op_done_i = '0;
        task_vld_i = 1'b1; task_i = {1'b0, 3'd7, 68'h0};
        #1;
        n_tests++; if (task_rdy_o !== 1'b1) begin n_fail++; $display("FAIL t1_end_rdy: got %b want 1", task_rdy_o); end
        step();
        task_vld_i = 1'b0;
        n_tests++; if ({start_o, done_o} !== 8'b0) begin n_fail++; $display("FAIL t1_drain: got start %b done %b want 0", start_o, done_o); end
        step();
        n_tests++; if ({done_o, busy_o} !== 2'b11) begin n_fail++; $display("FAIL t1_done: got done,busy %b want 11", {done_o, busy_o}); end
        step();
        n_tests++; if ({done_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL t1_idle: got done,busy %b want 00", {done_o, busy_o}); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b want 0", err_o); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = st3_cnt;
        do_run();
        task_vld_i = 1'b1; task_i = {1'b0, 3'd3, 68'h111};
        #1;
        n_tests++; if (task_rdy_o !== 1'b1) begin n_fail++; $display("FAIL t2_rdy_first: got %b want 1", task_rdy_o); end
        step();
        task_i = {1'b0, 3'd3, 68'h222};
        #1;
        n_tests++; if (task_rdy_o !== 1'b0) begin n_fail++; $display("FAIL t2_blocked: got %b want 0", task_rdy_o); end
        n_tests++; if (task_o[3] !== 68'h111) begin n_fail++; $display("FAIL t2_task_first: got %h want 111", task_o[3]); end
        step();
        step();
        op_done_i[3] = 1'b1;
        #1;
        n_tests++; if (task_rdy_o !== 1'b0) begin n_fail++; $display("FAIL t2_no_bypass: got %b want 0", task_rdy_o); end
        step();
        op_done_i = '0;
        #1;
        n_tests++; if (task_rdy_o !== 1'b1) begin n_fail++; $display("FAIL t2_rdy_after: got %b want 1", task_rdy_o); end
        step();
        task_vld_i = 1'b0;
        n_tests++; if (start_o !== 7'b0001000) begin n_fail++; $display("FAIL t2_start2: got %b want 0001000", start_o); end
        n_tests++; if (task_o[3] !== 68'h222) begin n_fail++; $display("FAIL t2_task_second: got %h want 222", task_o[3]); end
        op_done_i[3] = 1'b1;   // completion in the start cycle
        step();
        op_done_i = '0;
        end_drain();
        n_tests++; if (st3_cnt - base !== 2) begin n_fail++; $display("FAIL t2_start_count: got %0d want 2", st3_cnt - base); end
        n_tests++; if ({busy_o, err_o} !== 2'b00) begin n_fail++; $display("FAIL t2_end_state: got busy,err %b want 00", {busy_o, err_o}); end
    endtask

    task automatic test_barrier();
        do_run();
        task_vld_i = 1'b1; task_i = {1'b0, 3'd0, 68'hC0};
        step();
        task_i = {1'b0, 3'd5, 68'hC5};
        step();
        task_i = {1'b1, 3'd1, 68'hBB};
        #1;
        n_tests++; if (task_rdy_o !== 1'b0) begin n_fail++; $display("FAIL t3_bar_wait: got %b want 0", task_rdy_o); end
        step();
        op_done_i[0] = 1'b1;
        step();
        op_done_i = '0;
        #1;
        n_tests++; if (task_rdy_o !== 1'b0) begin n_fail++; $display("FAIL t3_bar_one_left: got %b want 0", task_rdy_o); end
        op_done_i[5] = 1'b1;
        #1;
        n_tests++; if (task_rdy_o !== 1'b0) begin n_fail++; $display("FAIL t3_bar_done_cycle: got %b want 0", task_rdy_o); end
        step();
        op_done_i = '0;
        #1;
        n_tests++; if (task_rdy_o !== 1'b1) begin n_fail++; $display("FAIL t3_bar_rdy: got %b want 1", task_rdy_o); end
        step();
        task_vld_i = 1'b0;
        n_tests++; if (start_o !== 7'b0000010) begin n_fail++; $display("FAIL t3_start1: got %b want 0000010", start_o); end
        n_tests++; if ({task_o[1], task_o[0], task_o[5]} !== {68'hBB, 68'hC0, 68'hC5}) begin n_fail++; $display("FAIL t3_task_o: got %h %h %h want bb c0 c5", task_o[1], task_o[0], task_o[5]); end
        op_done_i[1] = 1'b1;
        step();
        op_done_i = '0;
        end_drain();
        n_tests++; if ({busy_o, err_o} !== 2'b00) begin n_fail++; $display("FAIL t3_end_state: got busy,err %b want 00", {busy_o, err_o}); end
    endtask

    task automatic test_spurious_done();
        do_run();
        op_done_i[4] = 1'b1;
        step();
        op_done_i = '0;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL t4_err: got %b want 1", err_o); end
        n_tests++; if (start_o !== 7'b0) begin n_fail++; $display("FAIL t4_no_start: got %b want 0", start_o); end
        task_vld_i = 1'b1; task_i = {1'b0, 3'd4, 68'h4};
        #1;
        n_tests++; if (task_rdy_o !== 1'b1) begin n_fail++; $display("FAIL t4_busy_unchanged: got %b want 1", task_rdy_o); end
        task_vld_i = 1'b0;
        step();
        step();
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL t4_err_sticky: got %b want 1", err_o); end
        end_drain();
    endtask

    task automatic test_async_reset();
        do_run();
        task_vld_i = 1'b1; task_i = {1'b0, 3'd6, 68'h66};
        step();
        task_vld_i = 1'b0;
        n_tests++; if (start_o !== 7'b1000000) begin n_fail++; $display("FAIL t5_start6: got %b want 1000000", start_o); end
        rst_n = 1'b0;
        task_vld_i = 1'b1; task_i = {1'b0, 3'd0, 68'h1};
        #1;
        n_tests++; if ({start_o, busy_o, done_o, err_o, task_rdy_o} !== 11'b0) begin n_fail++; $display("FAIL t5_async_flags: got start %b busy %b done %b err %b rdy %b want 0", start_o, busy_o, done_o, err_o, task_rdy_o); end
        n_tests++; if (task_o !== '0) begin n_fail++; $display("FAIL t5_async_task_o: got %h want 0", task_o); end
        step();
        rst_n = 1'b1;
        step();
        n_tests++; if (task_rdy_o !== 1'b0) begin n_fail++; $display("FAIL t5_rdy_before_run: got %b want 0", task_rdy_o); end
        task_vld_i = 1'b0;
        op_done_i[6] = 1'b1;   // cluster 6 was still running
        step();
        op_done_i = '0;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL t5_late_done_err: got %b want 1", err_o); end
        do_run();
        task_vld_i = 1'b1;
        #1;
        n_tests++; if (task_rdy_o !== 1'b1) begin n_fail++; $display("FAIL t5_rdy_after_run: got %b want 1", task_rdy_o); end
        task_vld_i = 1'b0;
        end_drain();
    endtask

`ifdef FALCONSOAR_DISPATCH_PERF_EN
    task automatic test_perf();
        do_run();
        n_tests++; if ({perf_task_cnt_o, perf_stall_cnt_o} !== 64'h0) begin n_fail++; $display("FAIL t6_clear: got %0d %0d want 0 0", perf_task_cnt_o, perf_stall_cnt_o); end
        for (int c = 0; c < 4; c++) begin
            task_vld_i = 1'b1; task_i = {1'b0, 3'(c), 68'(c)};
            step();
        end
        task_i = {1'b0, 3'd0, 68'h50};
        step();
        step();
        op_done_i[0] = 1'b1;
        step();
        op_done_i = '0;
        step();
        task_vld_i = 1'b0;
        step();
        n_tests++; if (perf_task_cnt_o !== 32'd5) begin n_fail++; $display("FAIL t6_task_cnt: got %0d want 5", perf_task_cnt_o); end
        n_tests++; if (perf_stall_cnt_o !== 32'd3) begin n_fail++; $display("FAIL t6_stall_cnt: got %0d want 3", perf_stall_cnt_o); end
        op_done_i = 7'b0001111;
        step();
        op_done_i = '0;
        end_drain();
        do_run();
        n_tests++; if ({perf_task_cnt_o, perf_stall_cnt_o} !== 64'h0) begin n_fail++; $display("FAIL t6_clear_rerun: got %0d %0d want 0 0", perf_task_cnt_o, perf_stall_cnt_o); end
        end_drain();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_barrier();
        test_spurious_done();
        test_async_reset();
`ifdef FALCONSOAR_DISPATCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
